// File: rtl/lcd_ctrl_param_if.sv
// Controller bus bundle: host command strobe, IROM read port and IRAM write port.
// The controller side (master) drives both memory address buses and the status flags.
interface lcd_ctrl_param_if #(
  parameter int IMG_W = 8,
  parameter int DW    = 8
);
  localparam int AW = 2 * $clog2(IMG_W);

  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image-buffer LCD controller: loads IMG_W x IMG_W pixels from IROM, applies 2x2
// window commands around a movable point, and streams the buffer to IRAM on command 0.
module lcd_ctrl_param #(
  parameter int IMG_W     = 8,
  parameter int DW        = 8,
  parameter int AVG_ROUND = 0
) (
  input  logic             clk,
  input  logic             reset,
  lcd_ctrl_param_if.master bus
);
  localparam int LW = $clog2(IMG_W);
  localparam int AW = 2 * LW;
  localparam int N  = IMG_W * IMG_W;
  localparam logic [AW-1:0]   LAST = AW'(N - 1);
  localparam logic [LW-1:0]   CTR  = LW'(IMG_W / 2);
  localparam logic [LW-1:0]   PMAX = LW'(IMG_W - 1);
  localparam logic [LW-1:0]   PMIN = LW'(1);
  localparam logic [DW+1:0]   RND  = (DW+2)'(AVG_ROUND != 0 ? 2 : 0);

  typedef enum logic [1:0] {LOAD, IDLE, EXEC, WRITE} state_t;

  state_t        state;
  logic [LW-1:0] x, y;
  logic [3:0]    op;
  logic          cap_vld;
  logic [AW-1:0] cap_addr;
  logic [AW-1:0] wr_idx;
  logic          wr_end;
  logic [DW-1:0] pix [N];

  logic [LW-1:0] xm, ym;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] v0, v1, v2, v3, n0, n1, n2, n3;
  logic [DW-1:0] mx, mn, mx01, mx23, mn01, mn23;
  logic [DW+1:0] sum, avg;
  logic          win_we;

  // Window P0..P3 = (x-1,y-1),(x,y-1),(x-1,y),(x,y); row-major address is {row,col}.
  always_comb begin
    xm   = x - 1'b1;
    ym   = y - 1'b1;
    a0   = {ym, xm};
    a1   = {ym, x};
    a2   = {y, xm};
    a3   = {y, x};
    v0   = pix[a0];
    v1   = pix[a1];
    v2   = pix[a2];
    v3   = pix[a3];
    mx01 = (v0 > v1) ? v0 : v1;
    mx23 = (v2 > v3) ? v2 : v3;
    mx   = (mx01 > mx23) ? mx01 : mx23;
    mn01 = (v0 < v1) ? v0 : v1;
    mn23 = (v2 < v3) ? v2 : v3;
    mn   = (mn01 < mn23) ? mn01 : mn23;
    sum  = {2'b00, v0} + {2'b00, v1} + {2'b00, v2} + {2'b00, v3};
    avg  = (sum + RND) >> 2;
    win_we = 1'b0;
    {n0, n1, n2, n3} = {v0, v1, v2, v3};
    if (state == EXEC) begin
      win_we = 1'b1;
      case (op)
        4'd5:    {n0, n1, n2, n3} = {mx, mx, mx, mx};
        4'd6:    {n0, n1, n2, n3} = {mn, mn, mn, mn};
        4'd7:    {n0, n1, n2, n3} = {4{avg[DW-1:0]}};
        4'd8:    {n0, n1, n2, n3} = {v1, v3, v0, v2};
        4'd9:    {n0, n1, n2, n3} = {v2, v0, v3, v1};
        4'd10:   {n0, n1, n2, n3} = {v2, v3, v0, v1};
        4'd11:   {n0, n1, n2, n3} = {v1, v0, v3, v2};
        default: win_we = 1'b0;
      endcase
    end
  end

  // Pixel store carries no reset: a reset always forces a full reload.
  always_ff @(posedge clk) begin
    if (state == LOAD && cap_vld) begin
      pix[cap_addr] <= bus.IROM_Q;
    end else if (win_we) begin
      pix[a0] <= n0;
      pix[a1] <= n1;
      pix[a2] <= n2;
      pix[a3] <= n3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= LOAD;
      bus.busy       <= 1'b1;
      bus.IROM_rd    <= 1'b1;
      bus.IROM_A     <= '0;
      bus.IRAM_valid <= 1'b0;
      bus.IRAM_D     <= '0;
      bus.IRAM_A     <= '0;
      bus.done       <= 1'b0;
      x              <= CTR;
      y              <= CTR;
      op             <= '0;
      cap_vld        <= 1'b0;
      cap_addr       <= '0;
      wr_idx         <= '0;
      wr_end         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      // IROM data lags its address by one cycle, so capture trails the request.
      cap_vld  <= bus.IROM_rd;
      cap_addr <= bus.IROM_A;
      case (state)
        LOAD: begin
          if (bus.IROM_rd) begin
            if (bus.IROM_A == LAST) bus.IROM_rd <= 1'b0;
            else                    bus.IROM_A  <= bus.IROM_A + 1'b1;
          end
          if (cap_vld && cap_addr == LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.cmd_valid) begin
            op       <= bus.cmd;
            bus.busy <= 1'b1;
            state    <= (bus.cmd == 4'd0) ? WRITE : EXEC;
          end
        end
        EXEC: begin
          case (op)
            4'd1:  if (y > PMIN) y <= y - 1'b1;
            4'd2:  if (y < PMAX) y <= y + 1'b1;
            4'd3:  if (x > PMIN) x <= x - 1'b1;
            4'd4:  if (x < PMAX) x <= x + 1'b1;
            4'd12: begin x <= CTR; y <= CTR; end
            default: ;
          endcase
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        WRITE: begin
          if (!wr_end) begin
            bus.IRAM_valid <= 1'b1;
            bus.IRAM_A     <= wr_idx;
            bus.IRAM_D     <= pix[wr_idx];
            if (wr_idx == LAST) wr_end <= 1'b1;
            else                wr_idx <= wr_idx + 1'b1;
          end else begin
            bus.IRAM_valid <= 1'b0;
            bus.done       <= 1'b1;
            bus.busy       <= 1'b0;
            wr_idx         <= '0;
            wr_end         <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
